pipe_stall_ctrl: RTL

- Pipeline stall/flush controller for the 5-stage MIPS core.
- Sits directly downstream of the data-conflict/forwarding logic and consumes its LOAD_USE output.
- Also takes branch, multi-cycle divide and exception/ERET events.
- Drives per-stage register enables and flushes, the PC redirect select, and a stall performance counter.

---
 rtl/pipe_stall_ctrl_pkg.sv | 28 ++
 rtl/pipe_stall_ctrl_div_countdown.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller:
// FSM states and PC redirect source selects.
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_DIV_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_EXC = 2'd2;
  localparam logic [1:0] SEL_EPC = 2'd3;

  // Exception beats ERET when both are presented in the same cycle.
  function automatic logic [1:0] trap_sel(input logic exc, input logic eret);
    logic [1:0] sel;
    if (exc) begin
      sel = SEL_EXC;
    end else if (eret) begin
      sel = SEL_EPC;
    end else begin
      sel = SEL_SEQ;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_countdown.sv
// Divide occupancy countdown: synchronous clear, load, decrement
// (saturating at zero) and a zero flag.
module pipe_stall_ctrl_div_countdown #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register; clear outranks load, load outranks decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core: arbitrates trap,
// divide, load-use and taken-branch events into stage enables, flushes and
// the PC redirect select, and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_i,
  input  logic        branch_taken_id,
  input  logic        div_start_ex,
  input  logic        exc_req_mem,
  input  logic        eret_mem,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  redirect_sel,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_stall_cycles;

  logic        w_cnt_clr;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_zero;

  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_ifid_flush;
  logic        w_idex_en;
  logic        w_idex_flush;
  logic        w_exmem_flush;
  logic [1:0]  w_redirect_sel;
  logic        w_div_busy;
  logic        w_div_done;

  pipe_stall_ctrl_div_countdown #(
    .CNT_W (CNT_W)
  ) u_div_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (DIV_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; traps override every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_en      = 1'b1;
    w_idex_flush   = 1'b0;
    w_exmem_flush  = 1'b0;
    w_redirect_sel = SEL_SEQ;
    w_div_busy     = 1'b0;
    w_div_done     = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;

    if (exc_req_mem || eret_mem) begin
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_exmem_flush  = 1'b1;
      w_redirect_sel = trap_sel(exc_req_mem, eret_mem);
      w_state_nxt    = ST_RUN;
      w_cnt_clr      = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (div_start_ex) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_div_busy    = 1'b1;
            w_cnt_load    = 1'b1;
            w_state_nxt   = ST_DIV_WAIT;
          end else if (load_use_i) begin
            // A pending branch is dropped here and re-resolves next cycle.
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end else if (branch_taken_id) begin
            w_redirect_sel = SEL_BR;
            w_ifid_flush   = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DIV_WAIT: begin
          w_div_busy = 1'b1;
          if (w_cnt_zero) begin
            w_div_done  = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_cnt_dec     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // Stalled-cycle performance counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (!w_pc_en) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  // Reset asynchronously forces every control output inactive.
  assign pc_en        = w_pc_en       & rst_n;
  assign ifid_en      = w_ifid_en     & rst_n;
  assign ifid_flush   = w_ifid_flush  & rst_n;
  assign idex_en      = w_idex_en     & rst_n;
  assign idex_flush   = w_idex_flush  & rst_n;
  assign exmem_flush  = w_exmem_flush & rst_n;
  assign redirect_sel = w_redirect_sel & {2{rst_n}};
  assign div_busy     = w_div_busy    & rst_n;
  assign div_done     = w_div_done    & rst_n;
  assign stall_cycles = r_stall_cycles;

endmodule
